// File: rtl/muldiv_scheduler.sv
// HI/LO multiply/divide sequencer: latches operands, models fixed latency, drives HI/LO writes and D-stage stall.
// Optional MADD/MSUB accumulate support is enabled by defining MULDIV_MADD_EN.
module muldiv_scheduler #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cancel,
  input  logic        md_use,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_q,
  input  logic [31:0] lo_q,
  output logic        busy,
  output logic        stall,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {IDLE, RUN, COMMIT} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  localparam logic [3:0] MUL_CNT = 4'(MULT_LAT - 2);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 2);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;

  logic        is_mul, is_div, req, accept;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        div_signed, a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, b_div, quo_mag, rem_mag, quo, rem;

  // reset is folded into the request so nothing is written or stalled while held in reset
  assign req    = start & ~cancel & reset;
  assign accept = req & (state_q == IDLE);
  assign is_div = (op == OP_DIV) | (op == OP_DIVU);

`ifdef MULDIV_MADD_EN
  logic [63:0] madd_res, msub_res;
  assign is_mul   = (op == OP_MULT) | (op == OP_MULTU) | (op == OP_MADD) | (op == OP_MSUB);
  assign madd_res = {hi_q, lo_q} + prod_s;
  assign msub_res = {hi_q, lo_q} - prod_s;
`else
  logic acc_unused;
  assign is_mul     = (op == OP_MULT) | (op == OP_MULTU);
  assign acc_unused = ^{hi_q, lo_q};
`endif

  assign a_sx   = {{32{a_q[31]}}, a_q};
  assign b_sx   = {{32{b_q[31]}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide on magnitudes: 0x80000000 / -1 naturally yields LO = 0x80000000, HI = 0
  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag      = b_neg ? (~b_q + 32'd1) : b_q;
  assign b_zero     = (b_q == 32'd0);
  assign b_div      = b_zero ? 32'd1 : b_mag;
  assign quo_mag    = a_mag / b_div;
  assign rem_mag    = a_mag % b_div;
  assign quo        = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem        = a_neg ? (~rem_mag + 32'd1) : rem_mag;

  assign busy  = (state_q != IDLE);
  assign stall = md_use & (busy | (req & (is_mul | is_div)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wdata = 32'd0;
    lo_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul | is_div) begin
            op_d    = op;
            a_d     = a;
            b_d     = b;
            cnt_d   = is_div ? DIV_CNT : MUL_CNT;
            state_d = RUN;
          end else if (op == OP_MTHI) begin
            hi_we    = 1'b1;
            hi_wdata = a;
          end else if (op == OP_MTLO) begin
            lo_we    = 1'b1;
            lo_wdata = a;
          end
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) state_d = COMMIT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      COMMIT: begin
        state_d = IDLE;
        case (op_q)
          OP_MULT:  begin hi_we = 1'b1; lo_we = 1'b1; {hi_wdata, lo_wdata} = prod_s; end
          OP_MULTU: begin hi_we = 1'b1; lo_we = 1'b1; {hi_wdata, lo_wdata} = prod_u; end
          OP_DIV, OP_DIVU: begin
            if (!b_zero) begin
              hi_we    = 1'b1;
              lo_we    = 1'b1;
              hi_wdata = rem;
              lo_wdata = quo;
            end
          end
`ifdef MULDIV_MADD_EN
          OP_MADD:  begin hi_we = 1'b1; lo_we = 1'b1; {hi_wdata, lo_wdata} = madd_res; end
          OP_MSUB:  begin hi_we = 1'b1; lo_we = 1'b1; {hi_wdata, lo_wdata} = msub_res; end
`endif
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/muldiv_scheduler.md
# muldiv_scheduler

Sequencing controller for the HI/LO multiply/divide unit of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the E stage and latches their operands. It models the fixed multi-cycle latency of the arithmetic with a small FSM, and drives the write-enable and write-data inputs of the HI/LO result register. It also produces the busy/stall signal that the hazard unit uses to hold any HI/LO-touching instruction in D.

## Interface
- MULT_LAT, 5: busy cycles for MULT/MULTU (and MADD/MSUB); must be ≥ 2.
- DIV_LAT, 10: busy cycles for DIV/DIVU; must be ≥ 2.
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request valid in E stage this cycle.
- op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- cancel  in  1  squash the request presented this cycle (exception/flush).
- md_use  in  1  instruction in D reads or writes HI/LO (mf*/mt*/mult/div family).
- a, b  in  32 each  operands (rs, rt).
- hi_q, lo_q  in  32 each  current HI/LO values; used only with MULDIV_MADD_EN.
- busy  out  1  unit occupied.
- stall  out  1  hold D stage.
- hi_we, lo_we  out  1 each  result-register write enables.
- hi_wdata, lo_wdata  out  32 each  result-register write data.

## Operation
- States: IDLE, RUN, COMMIT. Internal registers: 4-bit down-counter `cnt`, latched `op_r`, `a_r`, `b_r`.
- Accept condition: start & ~cancel & state==IDLE.
- Accepted MULT-family or DIV-family op:
  - latch op and operands;
  - go to RUN with cnt = LAT−2, where LAT is MULT_LAT or DIV_LAT.
- RUN: decrement cnt each cycle; at cnt==0, go to COMMIT next.
- COMMIT: assert hi_we = lo_we = 1 with the computed results for exactly one cycle; then go to IDLE.
- Accepted MTHI/MTLO: combinational in the same cycle.
  - MTHI: hi_we = 1, hi_wdata = a. MTLO: lo_we = 1, lo_wdata = a.
  - State stays IDLE; busy is not asserted.
- Arithmetic, computed in COMMIT from the latched operands:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (b_r==0): full latency still elapses, but hi_we = lo_we = 0 in COMMIT, so HI/LO are unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- busy = (state != IDLE).
- stall = md_use & (busy | (start & ~cancel & op is MULT/DIV/MADD/MSUB)).
- start while busy: ignored, with no state change. The stall guarantees this never occurs legally.
- cancel together with start: request dropped. cancel has no effect on an operation already in RUN/COMMIT; the in-flight op always completes.
- Reset, asynchronous at any time including mid-operation:
  - state = IDLE, cnt = 0, op_r/a_r/b_r = 0;
  - busy = stall = hi_we = lo_we = 0, hi_wdata = lo_wdata = 0;
  - the in-flight operation is abandoned with no HI/LO write.

## Timing
- An operation accepted at edge E0 gives busy high for exactly LAT cycles: (LAT−1) RUN cycles plus 1 COMMIT cycle.
- The write enables are high in the last busy cycle. The new HI/LO values are registered at edge E0+LAT.
- A new request can be accepted in the first IDLE cycle after COMMIT.
- mfhi/mflo waiting in D is released on the cycle busy drops. Because the result register is write-through, it reads the new value.
- MTHI/MTLO: zero busy cycles; HI/LO are updated at the edge that ends the request cycle.
- Outputs hi_we, lo_we, hi_wdata and lo_wdata are combinational from state and latched data (plus start/op/a for MT*). stall is combinational from md_use and start.

## Configuration
- MULDIV_MADD_EN defined:
  - op 110 (MADD) and 111 (MSUB) are accepted with MULT_LAT latency.
  - In COMMIT, {HI,LO} = {hi_q,lo_q} ± signed a_r*b_r, modulo 2^64, using hi_q/lo_q sampled in the COMMIT cycle.
- Not defined:
  - op 110/111 are treated as no-ops: never accepted, no busy, no write, no stall contribution.
  - hi_q/lo_q are unused.

## Test plan
- MULT, a = 0xFFFFFFFE, b = 3 → busy high for 5 cycles; write in cycle 5 with HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV, a = −7 (0xFFFFFFF9), b = 2 → busy for 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU, a = 0x80000000, b = 0 → 10 busy cycles and no write enable.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- MTHI a = 0x12345678 while IDLE → hi_we in the same cycle, busy stays 0. With md_use = 1 during a MULT → stall high for all 5 busy cycles and for the start cycle, then low.
- reset pulsed low in RUN cycle 3 of a DIV → all outputs 0 immediately and no write. start+cancel → no busy, no write. A second start during RUN → ignored, and the original result is written unchanged.
- With MULDIV_MADD_EN: hi_q = 0, lo_q = 0xFFFFFFFF, MADD 1*1 → HI = 1, LO = 0. Without the macro, op 110 → no busy, no write.
